llr_frame_ctrl: RTL and testbench

LLR_FRAME_CTRL -- requirements
Module: llr_frame_ctrl

---
 rtl/llr_frame_ctrl_if.sv | 29 ++
 rtl/llr_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_llr_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/llr_frame_ctrl_if.sv
// Bundle of the sample-input, decoder-handshake and statistics signals of llr_frame_ctrl.
// The slave side is the frame controller; the master side is the sample source / decoder.
interface llr_frame_ctrl_if #(
    parameter int DATA_W = 5,
    parameter int DIM    = 2304,
    parameter int ERR_W  = 12,
    parameter int FRM_W  = 16
);
    logic                    in_valid;
    logic [DATA_W-1:0]       in_llr;
    logic                    in_ready;
    logic                    dec_start;
    logic [DIM*DATA_W-1:0]   dec_sig;
    logic                    dec_done;
    logic [DIM-1:0]          dec_res;
    logic [ERR_W-1:0]        errs;
    logic [FRM_W-1:0]        frames;
    logic [FRM_W-1:0]        frame_errs;

    modport master (
        output in_valid, in_llr, dec_done, dec_res,
        input  in_ready, dec_start, dec_sig, errs, frames, frame_errs
    );

    modport slave (
        input  in_valid, in_llr, dec_done, dec_res,
        output in_ready, dec_start, dec_sig, errs, frames, frame_errs
    );
endinterface

// File: rtl/llr_frame_ctrl.sv
// LLR frame controller: collects samples into ping/pong frame buffers, launches the
// decoder on the oldest full buffer, then counts bit errors of the decoder result one
// CHUNK slice per cycle and keeps error / frame statistics.
module llr_frame_ctrl #(
    parameter int DATA_W = 5,
    parameter int DIM    = 2304,
    parameter int CHUNK  = 96,
    parameter int ERR_W  = 12,
    parameter int FRM_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    llr_frame_ctrl_if.slave    bus
);
    localparam int BUF_W = DIM * DATA_W;
    localparam int NCH   = DIM / CHUNK;
    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SUM_W = $clog2(DIM + 1);
    localparam int EW    = ((ERR_W > SUM_W) ? ERR_W : SUM_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [DIM-1:0]     res_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic [ERR_W-1:0]   errs_reg;
    logic [FRM_W-1:0]   frames_reg;
    logic [FRM_W-1:0]   frame_errs_reg;

    logic [BUF_W-1:0]   buf_q  [2];
    logic               full_q [2];

    logic               accept;
    logic               frame_last;
    logic               count_last;
    logic [CHUNK-1:0]   chunk_bits;
    logic [SUM_W-1:0]   chunk_pop;
    logic [SUM_W-1:0]   frame_total;
    logic [EW-1:0]      errs_wide;
    logic [ERR_W-1:0]   errs_next;

    // Writing is only blocked when the buffer we would fill next still holds an undecoded frame.
    assign bus.in_ready = !full_q[wr_ptr_reg];
    assign accept       = bus.in_valid && bus.in_ready;
    assign frame_last   = accept && (cnt_reg == CNT_W'(DIM - 1));
    assign count_last   = (state_reg == COUNT) && (idx_reg == IDX_W'(NCH - 1));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_buf
            logic [BUF_W-1:0] buf_reg;
            logic             full_reg;
            logic             wr_sel;
            logic             rd_sel;

            assign wr_sel = (wr_ptr_reg == 1'(gi));
            assign rd_sel = (rd_ptr_reg == 1'(gi));

            // Shift samples in at the bottom; the full flag is set by the last sample and
            // cleared when the decode of this buffer finishes (never both in one cycle).
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_reg  <= '0;
                    full_reg <= 1'b0;
                end else begin
                    if (accept && wr_sel) begin
                        buf_reg <= {buf_reg[BUF_W-DATA_W-1:0], bus.in_llr};
                    end
                    if (frame_last && wr_sel) begin
                        full_reg <= 1'b1;
                    end else if (count_last && rd_sel) begin
                        full_reg <= 1'b0;
                    end
                end
            end

            assign buf_q[gi]  = buf_reg;
            assign full_q[gi] = full_reg;
        end
    endgenerate

    // Sample counter and ping/pong pointers; frames are decoded in the order they were written.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (frame_last) begin
                cnt_reg    <= '0;
                wr_ptr_reg <= !wr_ptr_reg;
            end else if (accept) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (count_last) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
        end
    end

    // Decode FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Decode FSM next-state: launch on a full buffer, wait for the decoder, then count errors.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (full_q[rd_ptr_reg]) state_next = RUN;
            RUN:     if (bus.dec_done)       state_next = COUNT;
            COUNT:   if (count_last)         state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Decode FSM outputs: start pulse and the frame held steady for the decoder.
    always_comb begin
        bus.dec_start = 1'b0;
        bus.dec_sig   = '0;
        if (state_reg == IDLE) begin
            if (full_q[rd_ptr_reg]) begin
                bus.dec_start = 1'b1;
                bus.dec_sig   = buf_q[rd_ptr_reg];
            end
        end else begin
            bus.dec_sig = buf_q[rd_ptr_reg];
        end
    end

    // Popcount of the current result slice plus the running per-frame sum.
    always_comb begin
        chunk_bits = res_reg[idx_reg*CHUNK +: CHUNK];
        chunk_pop  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + SUM_W'(chunk_bits[i]);
        end
        frame_total = sum_reg + chunk_pop;
        errs_wide   = EW'(errs_reg) + EW'(frame_total);
        errs_next   = (|errs_wide[EW-1:ERR_W]) ? {ERR_W{1'b1}} : errs_wide[ERR_W-1:0];
    end

    // Result capture, slice-by-slice error counting and the statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg        <= '0;
            idx_reg        <= '0;
            sum_reg        <= '0;
            errs_reg       <= '0;
            frames_reg     <= '0;
            frame_errs_reg <= '0;
        end else begin
            if (state_reg == RUN && bus.dec_done) begin
                res_reg <= bus.dec_res;
                idx_reg <= '0;
                sum_reg <= '0;
            end else if (state_reg == COUNT) begin
                if (count_last) begin
                    idx_reg    <= '0;
                    sum_reg    <= '0;
                    errs_reg   <= errs_next;
                    frames_reg <= frames_reg + FRM_W'(1);
                    if (frame_total != '0) begin
                        frame_errs_reg <= frame_errs_reg + FRM_W'(1);
                    end
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                    sum_reg <= frame_total;
                end
            end
        end
    end

    assign bus.errs       = errs_reg;
    assign bus.frames     = frames_reg;
    assign bus.frame_errs = frame_errs_reg;

endmodule

// File: tb/tb_llr_frame_ctrl.sv
// Self-checking bench for llr_frame_ctrl (DIM=8, DATA_W=5, CHUNK=4, ERR_W=4, FRM_W=4):
// a table of per-cycle vectors, hand sequences for back-pressure / reset / stray dec_done,
// and random traffic compared against a queue-based frame model.
module tb_llr_frame_ctrl;
    localparam int DATA_W = 5;
    localparam int DIM    = 8;
    localparam int CHUNK  = 4;
    localparam int ERR_W  = 4;
    localparam int FRM_W  = 4;
    localparam int SIG_W  = DIM * DATA_W;
    localparam int NCH    = DIM / CHUNK;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int FRM_MOD = 1 << FRM_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    llr_frame_ctrl_if #(.DATA_W(DATA_W), .DIM(DIM), .ERR_W(ERR_W), .FRM_W(FRM_W)) bus ();

    llr_frame_ctrl #(
        .DATA_W(DATA_W), .DIM(DIM), .CHUNK(CHUNK), .ERR_W(ERR_W), .FRM_W(FRM_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame with sample base+i in position i, first sample in the MSBs.
    function automatic logic [SIG_W-1:0] pack_seq(input int base);
        logic [SIG_W-1:0] f;
        f = '0;
        for (int i = 0; i < DIM; i++) f[(DIM-1-i)*DATA_W +: DATA_W] = DATA_W'(base + i);
        return f;
    endfunction

    // ---------------- reference model ----------------
    int               fill_q[$];
    logic [SIG_W-1:0] full_q[$];
    bit               m_busy, m_counting;
    int               m_left, m_sum, m_errs, m_frames, m_ferrs;

    task automatic model_reset();
        fill_q.delete();
        full_q.delete();
        m_busy = 0; m_counting = 0; m_left = 0; m_sum = 0;
        m_errs = 0; m_frames = 0; m_ferrs = 0;
    endtask

    task automatic model_check();
        logic [SIG_W-1:0] esig;
        esig = '0;
        if (full_q.size() > 0) esig = full_q[0];
        chk("in_ready",   64'(bus.in_ready),   64'(full_q.size() < 2));
        chk("dec_start",  64'(bus.dec_start),  64'(!m_busy && full_q.size() > 0));
        chk("dec_sig",    64'(bus.dec_sig),    64'(esig));
        chk("errs",       64'(bus.errs),       64'(m_errs));
        chk("frames",     64'(bus.frames),     64'(m_frames));
        chk("frame_errs", 64'(bus.frame_errs), 64'(m_ferrs));
    endtask

    task automatic model_step(input bit v, input logic [DATA_W-1:0] llr, input bit d,
                              input logic [DIM-1:0] res);
        bit rdy;
        bit start;
        logic [SIG_W-1:0] f;
        rdy   = full_q.size() < 2;
        start = !m_busy && full_q.size() > 0;
        if (m_counting) begin
            if (m_left == 1) begin
                m_errs   = (m_errs + m_sum > ERR_MAX) ? ERR_MAX : m_errs + m_sum;
                m_frames = (m_frames + 1) % FRM_MOD;
                if (m_sum != 0) m_ferrs = (m_ferrs + 1) % FRM_MOD;
                void'(full_q.pop_front());
                m_busy = 0;
                m_counting = 0;
                $display("frame decoded: bit_errs=%0d errs=%0d frames=%0d frame_errs=%0d",
                         m_sum, m_errs, m_frames, m_ferrs);
            end else begin
                m_left--;
            end
        end else if (m_busy && d) begin
            m_counting = 1;
            m_left     = NCH;
            m_sum      = $countones(res);
        end else if (start) begin
            m_busy = 1;
        end
        if (v && rdy) begin
            fill_q.push_back(int'(llr));
            if (fill_q.size() == DIM) begin
                f = '0;
                for (int i = 0; i < DIM; i++) f[(DIM-1-i)*DATA_W +: DATA_W] = DATA_W'(fill_q[i]);
                full_q.push_back(f);
                fill_q.delete();
            end
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model, clock.
    task automatic cyc(input bit v, input logic [DATA_W-1:0] llr, input bit d,
                       input logic [DIM-1:0] res);
        bus.in_valid = v; bus.in_llr = llr; bus.dec_done = d; bus.dec_res = res;
        #2;
        model_check();
        model_step(v, llr, d, res);
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle(input bit v, input logic [DATA_W-1:0] llr);
        bus.in_valid = v; bus.in_llr = llr; bus.dec_done = 1'b0; bus.dec_res = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},   64'(bus.in_ready),   64'd1);
        chk({tag, "_dec_start"},  64'(bus.dec_start),  64'd0);
        chk({tag, "_dec_sig"},    64'(bus.dec_sig),    64'd0);
        chk({tag, "_errs"},       64'(bus.errs),       64'd0);
        chk({tag, "_frames"},     64'(bus.frames),     64'd0);
        chk({tag, "_frame_errs"}, 64'(bus.frame_errs), 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit                 v;
        logic [DATA_W-1:0]  llr;
        bit                 d;
        logic [DIM-1:0]     res;
        bit                 e_ready;
        bit                 e_start;
        int                 e_frames;
        int                 e_errs;
        int                 e_ferrs;
        bit                 chk_sig;
        logic [SIG_W-1:0]   e_sig;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit v, input int llr, input bit d, input logic [DIM-1:0] res,
                           input bit es, input int fr, input int er, input int fe,
                           input bit cs, input logic [SIG_W-1:0] sig);
        vec_t r;
        r.v = v; r.llr = DATA_W'(llr); r.d = d; r.res = res;
        r.e_ready = 1'b1; r.e_start = es;
        r.e_frames = fr; r.e_errs = er; r.e_ferrs = fe;
        r.chk_sig = cs; r.e_sig = sig;
        tbl.push_back(r);
    endtask

    // One frame in a lone buffer: 8 samples, start pulse, done, two counting cycles.
    // Counters stay at their previous values throughout these 12 cycles.
    task automatic add_frame(input int base, input logic [DIM-1:0] res,
                             input int fr, input int er, input int fe);
        for (int i = 0; i < DIM; i++) add_vec(1, base + i, 0, '0, 0, fr, er, fe, 0, '0);
        add_vec(0, 0, 0, '0, 1, fr, er, fe, 1, pack_seq(base));
        add_vec(0, 0, 1, res, 0, fr, er, fe, 1, pack_seq(base));
        for (int i = 0; i < NCH; i++) add_vec(0, 0, 0, '0, 0, fr, er, fe, 1, pack_seq(base));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_llr = '0; bus.dec_done = 1'b0; bus.dec_res = '0;
        model_reset();

        add_frame(1,  8'b0000_0000, 0, 0,  0);
        add_frame(9,  8'b1000_0011, 1, 0,  0);
        add_frame(17, 8'b1000_0011, 2, 3,  1);
        add_frame(3,  8'b1000_0011, 3, 6,  2);
        add_frame(11, 8'b1000_0011, 4, 9,  3);
        add_frame(19, 8'b1000_0011, 5, 12, 4);
        add_frame(5,  8'b1000_0011, 6, 15, 5);
        add_vec(0, 0, 0, '0, 0, 7, 15, 6, 1, '0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset");

        // Table: frame flow, error accumulation and saturation at 15.
        foreach (tbl[k]) begin
            bus.in_valid = tbl[k].v; bus.in_llr = tbl[k].llr;
            bus.dec_done = tbl[k].d; bus.dec_res = tbl[k].res;
            #2;
            $display("vec %0d: v=%0d llr=%0d done=%0d start=%0d frames=%0d errs=%0d", k,
                     tbl[k].v, tbl[k].llr, tbl[k].d, bus.dec_start, bus.frames, bus.errs);
            chk($sformatf("tbl%0d_in_ready", k),   64'(bus.in_ready),   64'(tbl[k].e_ready));
            chk($sformatf("tbl%0d_dec_start", k),  64'(bus.dec_start),  64'(tbl[k].e_start));
            chk($sformatf("tbl%0d_frames", k),     64'(bus.frames),     64'(tbl[k].e_frames));
            chk($sformatf("tbl%0d_errs", k),       64'(bus.errs),       64'(tbl[k].e_errs));
            chk($sformatf("tbl%0d_frame_errs", k), 64'(bus.frame_errs), 64'(tbl[k].e_ferrs));
            if (tbl[k].chk_sig) chk($sformatf("tbl%0d_dec_sig", k), 64'(bus.dec_sig), 64'(tbl[k].e_sig));
            @(posedge clk); #1;
        end

        // Stray dec_done while idle leaves everything unchanged.
        bus.in_valid = 1'b0; bus.dec_done = 1'b1; bus.dec_res = '1;
        @(posedge clk); #1;
        bus.dec_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_done_frames",     64'(bus.frames),     64'd7);
        chk("idle_done_errs",       64'(bus.errs),       64'd15);
        chk("idle_done_frame_errs", 64'(bus.frame_errs), 64'd6);
        chk("idle_done_dec_start",  64'(bus.dec_start),  64'd0);

        // Back-pressure: 24 samples with the decoder answer withheld.
        reset_cycle(0, '0);
        chk_reset_state("bp_reset");
        for (int i = 0; i < 16; i++) cyc(1, DATA_W'(i + 1), 0, '0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
            cyc(1, DATA_W'(17), 0, '0);
        end
        cyc(1, DATA_W'(17), 1, 8'b0001_0000);
        cyc(1, DATA_W'(17), 0, '0);
        chk("bp_last_count_ready", 64'(bus.in_ready), 64'd0);
        cyc(1, DATA_W'(17), 0, '0);
        chk("bp_release_ready", 64'(bus.in_ready),  64'd1);
        chk("bp_second_start",  64'(bus.dec_start), 64'd1);
        chk("bp_second_sig",    64'(bus.dec_sig),   64'(pack_seq(9)));
        for (int i = 0; i < 8; i++) cyc(1, DATA_W'(17 + i), 0, '0);
        for (int i = 0; i < 30; i++) cyc(0, '0, (i % 5) == 2, DIM'(i * 37));

        // Reset during the 5th sample of frame 2 while frame 1 is being decoded.
        reset_cycle(0, '0);
        for (int i = 0; i < 8; i++) cyc(1, DATA_W'(i + 1), 0, '0);
        cyc(0, '0, 0, '0);
        cyc(0, '0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(1, DATA_W'(i + 9), 0, '0);
        reset_cycle(1, DATA_W'(13));
        chk_reset_state("midrst");
        cyc(0, '0, 1, '1);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, '0);
        chk("midrst_late_done_frames", 64'(bus.frames), 64'd0);
        for (int i = 0; i < 8; i++) cyc(1, DATA_W'(21 + i), 0, '0);
        chk("midrst_frame_a_start", 64'(bus.dec_start), 64'd1);
        chk("midrst_frame_a_sig",   64'(bus.dec_sig),   64'(pack_seq(21)));
        cyc(0, '0, 0, '0);
        cyc(0, '0, 1, 8'b0110_0000);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, '0);
        chk("midrst_frame_a_errs", 64'(bus.errs), 64'd2);

        // Random traffic against the model, with occasional resets.
        reset_cycle(0, '0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_cycle($urandom_range(0, 1) == 1, DATA_W'($urandom));
            end else begin
                cyc($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 2) == 0) ? '0 : DIM'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
